// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer for the single-cycle core. Holds the architectural
// PC and selects the next fetch address from sequential increment, a
// conditional PC-relative branch (B) or a conditional register-indirect branch
// (BR). Supports stall and a sticky halt, and keeps saturating branch
// statistics.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   stall        hold PC and state this cycle
//   halt         current instruction is HLT
//   branch_en    current instruction is B or BR
//   branch_reg   1 = BR (register target), 0 = B (PC-relative)
//   cond         condition code field
//   flags        {N,Z,V}
//   imm          signed branch offset in instructions
//   reg_target   BR target from register file
//   pc           current PC (registered)
//   pc_plus      pc + INC (combinational)
//   pc_next      value PC loads at the next edge (combinational)
//   taken        branch condition met this cycle (combinational)
//   halted       block is in HALTED state (registered)
//   align_err    one-cycle pulse after a taken BR with misaligned target
//   br_count     branches executed (saturating)
//   taken_count  branches taken (saturating)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                 ADDR_W   = 16,
    parameter int                 IMM_W    = 9,
    parameter int                 INC      = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = 16'h0000,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              branch_en,
    input  logic              branch_reg,
    input  logic [2:0]        cond,
    input  logic [2:0]        flags,
    input  logic [IMM_W-1:0]  imm,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic [ADDR_W-1:0] pc_next,
    output logic              taken,
    output logic              halted,
    output logic              align_err,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  taken_count
);

    // INC is a power of two; the immediate is scaled by the same amount and
    // BR targets have the matching low bits cleared.
    localparam int                SHIFT    = $clog2(INC);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_align_err;
    logic [CNT_W-1:0]    r_br_count;
    logic [CNT_W-1:0]    r_taken_count;

    logic [ADDR_W-1:0]   w_pc_plus;
    logic [ADDR_W-1:0]   w_pc_next;
    logic [ADDR_W-1:0]   w_imm_ext;
    logic [ADDR_W-1:0]   w_b_target;
    logic [ADDR_W-1:0]   w_br_target;
    logic                w_misalign;
    logic                w_taken;
    logic                w_cnt_en;
    logic                w_align_next;

    // Condition-code evaluation against {N,Z,V}.
    function automatic logic cond_true(input logic [2:0] c, input logic [2:0] f);
        logic n;
        logic z;
        logic v;
        logic res;
        n = f[2];
        z = f[1];
        v = f[0];
        case (c)
            3'b000:  res = !z;
            3'b001:  res = z;
            3'b010:  res = !z && !n;
            3'b011:  res = n;
            3'b100:  res = z || (!z && !n);
            3'b101:  res = n || z;
            3'b110:  res = v;
            3'b111:  res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Address arithmetic; all sums wrap modulo 2^ADDR_W.
    always_comb begin
        w_pc_plus   = r_pc + ADDR_W'(INC);
        w_imm_ext   = ADDR_W'($signed(imm));
        w_b_target  = w_pc_plus + (w_imm_ext << SHIFT);
        w_br_target = reg_target & ~LOW_MASK;
        w_misalign  = |(reg_target & LOW_MASK);
    end

    // Next-state, next-PC and side-effect enables; HALTED ignores all inputs.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_taken      = 1'b0;
        w_cnt_en     = 1'b0;
        w_align_next = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_taken = branch_en & cond_true(cond, flags);
                if (stall) begin
                    w_pc_next = r_pc;
                end else if (halt) begin
                    // Halt beats a simultaneous branch: no redirect, no count.
                    w_pc_next    = r_pc;
                    w_state_next = ST_HALTED;
                end else begin
                    w_cnt_en = branch_en;
                    if (w_taken) begin
                        w_pc_next    = branch_reg ? w_br_target : w_b_target;
                        w_align_next = branch_reg & w_misalign;
                    end else begin
                        w_pc_next = w_pc_plus;
                    end
                end
            end
            ST_HALTED: begin
                w_pc_next = r_pc;
            end
            default: begin
                w_state_next = ST_RUN;
                w_pc_next    = RESET_PC;
            end
        endcase
    end

    // State, PC, alignment pulse and saturating statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_align_err   <= 1'b0;
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_align_err <= w_align_next;
            if (w_cnt_en && (r_br_count != CNT_MAX)) begin
                r_br_count <= r_br_count + CNT_W'(1);
            end
            if (w_cnt_en && w_taken && (r_taken_count != CNT_MAX)) begin
                r_taken_count <= r_taken_count + CNT_W'(1);
            end
        end
    end

    assign pc          = r_pc;
    assign pc_plus     = w_pc_plus;
    assign pc_next     = w_pc_next;
    assign taken       = w_taken;
    assign halted      = (r_state == ST_HALTED);
    assign align_err   = r_align_err;
    assign br_count    = r_br_count;
    assign taken_count = r_taken_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed-vector bench for pc_sequencer (ADDR_W=16, INC=2). Each vector
// carries hand-computed expected outputs that are queued on issue; a monitor
// on the falling edge pops and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        halt;
    logic        branch_en;
    logic        branch_reg;
    logic [2:0]  cond;
    logic [2:0]  flags;
    logic [8:0]  imm;
    logic [15:0] reg_target;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic [15:0] pc_next;
    logic        taken;
    logic        halted;
    logic        align_err;
    logic [15:0] br_count;
    logic [15:0] taken_count;

    pc_sequencer #(
        .ADDR_W   (16),
        .IMM_W    (9),
        .INC      (2),
        .RESET_PC (16'h0000),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .halt        (halt),
        .branch_en   (branch_en),
        .branch_reg  (branch_reg),
        .cond        (cond),
        .flags       (flags),
        .imm         (imm),
        .reg_target  (reg_target),
        .pc          (pc),
        .pc_plus     (pc_plus),
        .pc_next     (pc_next),
        .taken       (taken),
        .halted      (halted),
        .align_err   (align_err),
        .br_count    (br_count),
        .taken_count (taken_count)
    );

    typedef struct {
        int          id;
        logic [15:0] pc;
        logic [15:0] nxt;
        logic        tk;
        logic        h;
        logic        al;
        logic [15:0] br;
        logic [15:0] tc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vec_id  = 0;

    // Taken truth table: bit {N,Z,V} of entry [cond].
    logic [7:0] tbl [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, int id, logic [15:0] act, logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s vec=%0d actual=%h required=%h", nm, id, act, req);
        end
    endfunction

    // Monitor: outputs are stable mid-cycle; compare against the queued entry.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m_e = sb.pop_front();
            chk("pc",          m_e.id, pc,                  m_e.pc);
            chk("pc_plus",     m_e.id, pc_plus,             m_e.pc + 16'd2);
            chk("pc_next",     m_e.id, pc_next,             m_e.nxt);
            chk("taken",       m_e.id, {15'd0, taken},      {15'd0, m_e.tk});
            chk("halted",      m_e.id, {15'd0, halted},     {15'd0, m_e.h});
            chk("align_err",   m_e.id, {15'd0, align_err},  {15'd0, m_e.al});
            chk("br_count",    m_e.id, br_count,            m_e.br);
            chk("taken_count", m_e.id, taken_count,         m_e.tc);
        end
    end

    task automatic vec(input logic t_rst, input logic t_stall, input logic t_halt,
                       input logic t_ben, input logic t_breg, input logic [2:0] t_cond,
                       input logic [2:0] t_flags, input logic [8:0] t_imm,
                       input logic [15:0] t_rt, input logic t_chk,
                       input logic [15:0] e_pc, input logic [15:0] e_nxt,
                       input logic e_tk, input logic e_h, input logic e_al,
                       input logic [15:0] e_br, input logic [15:0] e_tc);
        exp_t e;
        @(posedge clk);
        #1;
        rst        = t_rst;
        stall      = t_stall;
        halt       = t_halt;
        branch_en  = t_ben;
        branch_reg = t_breg;
        cond       = t_cond;
        flags      = t_flags;
        imm        = t_imm;
        reg_target = t_rt;
        vec_id++;
        if (t_chk) begin
            e.id = vec_id; e.pc = e_pc; e.nxt = e_nxt; e.tk = e_tk;
            e.h = e_h; e.al = e_al; e.br = e_br; e.tc = e_tc;
            sb.push_back(e);
        end
    endtask

    // Sequential cycle with branch_en low but an always-true condition.
    task automatic idle(input logic [15:0] e_pc, input logic e_h, input logic e_al,
                        input logic [15:0] e_br, input logic [15:0] e_tc);
        vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 9'h000, 16'h0000, 1'b1,
            e_pc, e_h ? e_pc : e_pc + 16'd2, 1'b0, e_h, e_al, e_br, e_tc);
    endtask

    task automatic do_reset();
        vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 9'h000, 16'h0000, 1'b0,
            16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog vec=%0d actual=timeout required=finish", vec_id);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = 8'h33; tbl[1] = 8'hCC; tbl[2] = 8'h03; tbl[3] = 8'hF0;
        tbl[4] = 8'hCF; tbl[5] = 8'hFC; tbl[6] = 8'hAA; tbl[7] = 8'hFF;
        rst = 1'b1; stall = 1'b0; halt = 1'b0; branch_en = 1'b0; branch_reg = 1'b0;
        cond = 3'b000; flags = 3'b000; imm = 9'h000; reg_target = 16'h0000;

        do_reset();
        do_reset();
        // Reset state and sequential increments
        idle(16'h0000, 1'b0, 1'b0, 16'd0, 16'd0);
        idle(16'h0002, 1'b0, 1'b0, 16'd0, 16'd0);
        idle(16'h0004, 1'b0, 1'b0, 16'd0, 16'd0);
        idle(16'h0006, 1'b0, 1'b0, 16'd0, 16'd0);
        // Wrap: BR to 0xFFFE then sequential to 0x0000
        vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 3'b000, 9'h000, 16'hFFFE, 1'b1,
            16'h0008, 16'hFFFE, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        idle(16'hFFFE, 1'b0, 1'b0, 16'd1, 16'd1);
        idle(16'h0000, 1'b0, 1'b0, 16'd1, 16'd1);

        do_reset();
        // B forward: 0x0002 + 7*2 = 0x0010
        vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 9'h007, 16'h0000, 1'b1,
            16'h0000, 16'h0010, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        // B with imm=-1 at 0x0010: 0x0012 - 2 = 0x0010
        vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 9'h1FF, 16'h0000, 1'b1,
            16'h0010, 16'h0010, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1);
        // cond=001 with Z=0: not taken, falls through
        vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 3'b000, 9'h004, 16'h0000, 1'b1,
            16'h0010, 16'h0012, 1'b0, 1'b0, 1'b0, 16'd2, 16'd2);
        idle(16'h0012, 1'b0, 1'b0, 16'd3, 16'd2);
        idle(16'h0014, 1'b0, 1'b0, 16'd3, 16'd2);

        // Condition sweep under stall: taken reflects table, nothing advances
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                vec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, c[2:0], f[2:0], 9'h004, 16'h0000, 1'b1,
                    16'h0016, 16'h0016, tbl[c][f], 1'b0, 1'b0, 16'd3, 16'd2);
            end
        end

        // BR to misaligned 0x1235 lands on 0x1234 with a one-cycle align_err
        vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 3'b000, 9'h000, 16'h1235, 1'b1,
            16'h0016, 16'h1234, 1'b1, 1'b0, 1'b0, 16'd3, 16'd2);
        idle(16'h1234, 1'b0, 1'b1, 16'd4, 16'd3);
        idle(16'h1236, 1'b0, 1'b0, 16'd4, 16'd3);

        // Stalled taken B holds; on release it completes: 0x123A + 10 = 0x1244
        vec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 9'h005, 16'h0000, 1'b1,
            16'h1238, 16'h1238, 1'b1, 1'b0, 1'b0, 16'd4, 16'd3);
        vec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 9'h005, 16'h0000, 1'b1,
            16'h1238, 16'h1238, 1'b1, 1'b0, 1'b0, 16'd4, 16'd3);
        vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 9'h005, 16'h0000, 1'b1,
            16'h1238, 16'h1244, 1'b1, 1'b0, 1'b0, 16'd4, 16'd3);
        idle(16'h1244, 1'b0, 1'b0, 16'd5, 16'd4);
        // Stalled misaligned BR raises no align_err
        vec(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b111, 3'b000, 9'h000, 16'h0041, 1'b1,
            16'h1246, 16'h1246, 1'b1, 1'b0, 1'b0, 16'd5, 16'd4);
        idle(16'h1246, 1'b0, 1'b0, 16'd5, 16'd4);

        // Go to 0x0040 and halt together with a branch: halt wins, no count
        vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 3'b000, 9'h000, 16'h0040, 1'b1,
            16'h1248, 16'h0040, 1'b1, 1'b0, 1'b0, 16'd5, 16'd4);
        vec(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b111, 3'b000, 9'h010, 16'h0000, 1'b1,
            16'h0040, 16'h0040, 1'b1, 1'b0, 1'b0, 16'd6, 16'd5);
        // Five halted cycles with assorted stimulus: everything frozen
        vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 9'h010, 16'h0000, 1'b1,
            16'h0040, 16'h0040, 1'b0, 1'b1, 1'b0, 16'd6, 16'd5);
        vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 3'b000, 9'h000, 16'h1235, 1'b1,
            16'h0040, 16'h0040, 1'b0, 1'b1, 1'b0, 16'd6, 16'd5);
        idle(16'h0040, 1'b1, 1'b0, 16'd6, 16'd5);
        vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 9'h000, 16'h0000, 1'b1,
            16'h0040, 16'h0040, 1'b0, 1'b1, 1'b0, 16'd6, 16'd5);
        idle(16'h0040, 1'b1, 1'b0, 16'd6, 16'd5);

        // Reset out of HALTED
        do_reset();
        idle(16'h0000, 1'b0, 1'b0, 16'd0, 16'd0);
        // Halt under stall is ignored
        vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 9'h000, 16'h0000, 1'b1,
            16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        idle(16'h0002, 1'b0, 1'b0, 16'd0, 16'd0);

        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain vec=%0d actual=%0d required=0", vec_id, sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
